// File: rtl/mmio_pkg.sv
// Shared types and constants for the CPU-to-memory/IO bridge.
package mmio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_ACK    = 2'd3
    } state_e;

    localparam logic [23:0] IO_BASE = 24'h00007F;

    localparam logic [7:0] IO_LED     = 8'h00;
    localparam logic [7:0] IO_BTN_SW  = 8'h04;
    localparam logic [7:0] IO_SEG_RDY = 8'h08;
    localparam logic [7:0] IO_SEG     = 8'h0C;
    localparam logic [7:0] IO_SWX_VLD = 8'h10;
    localparam logic [7:0] IO_SWX     = 8'h14;
    localparam logic [7:0] IO_CNT     = 8'h18;

    localparam logic [7:0]  IO_MAX   = IO_CNT;
    localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/mmio_decode.sv
// Address decode for the bridge: IO window detection and illegal IO offsets.
// Illegal-offset detection only exists when MMIO_ERR_EN is defined.
module mmio_decode
    import mmio_pkg::*;
(
    input  logic [31:0] addr,
    output logic        is_io,
    output logic        is_illegal
);

`ifdef MMIO_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic offset_bad;

    // Unaligned offsets and offsets past the last register are illegal.
    assign offset_bad = (addr[1:0] != 2'b00) || (addr[7:0] > IO_MAX);
    assign is_io      = (addr[31:8] == IO_BASE);
    assign is_illegal = ERR_EN && is_io && offset_bad;

endmodule

// File: rtl/mmio_bridge.sv
// Single-clock bridge from a CPU request/ack port to data memory and the PDU IO bus.
// Optional feature MMIO_ERR_EN: illegal IO accesses are suppressed and flagged on bus_err.
module mmio_bridge
    import mmio_pkg::*;
#(
    parameter int DM_AW = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [31:0]      cpu_addr,
    input  logic [31:0]      cpu_wdata,
    output logic [31:0]      cpu_rdata,
    output logic             cpu_ack,
    output logic             dm_we,
    output logic [DM_AW-1:0] dm_addr,
    output logic [31:0]      dm_wdata,
    input  logic [31:0]      dm_rdata,
    output logic [7:0]       io_addr,
    output logic [31:0]      io_dout,
    output logic             io_we,
    output logic             io_rd,
    input  logic [31:0]      io_din,
    output logic             bus_err
);

    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic              io_q, io_d;
    logic              ill_q, ill_d;
    logic [DM_AW-1:0]  dm_addr_q, dm_addr_d;
    logic [7:0]        io_addr_q, io_addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              ack_q, ack_d;
    logic              dm_we_q, dm_we_d;
    logic              io_we_q, io_we_d;
    logic              io_rd_q, io_rd_d;
    logic              bus_err_q, bus_err_d;

    logic dec_is_io;
    logic dec_is_illegal;

    mmio_decode u_decode (
        .addr       (cpu_addr),
        .is_io      (dec_is_io),
        .is_illegal (dec_is_illegal)
    );

    // Strobes are set on the accept edge so they are high exactly for the ACCESS cycle.
    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        io_d      = io_q;
        ill_d     = ill_q;
        dm_addr_d = dm_addr_q;
        io_addr_d = io_addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        bus_err_d = bus_err_q;
        ack_d     = 1'b0;
        dm_we_d   = 1'b0;
        io_we_d   = 1'b0;
        io_rd_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cpu_req) begin
                    state_d   = ST_ACCESS;
                    we_d      = cpu_we;
                    io_d      = dec_is_io;
                    ill_d     = dec_is_illegal;
                    dm_addr_d = cpu_addr[DM_AW+1:2];
                    io_addr_d = cpu_addr[7:0];
                    wdata_d   = cpu_wdata;
                    dm_we_d   = cpu_we && !dec_is_io;
                    io_we_d   = cpu_we && dec_is_io && !dec_is_illegal;
                    io_rd_d   = !cpu_we && dec_is_io && !dec_is_illegal;
                end
            end
            ST_ACCESS: begin
                if (!we_q && !io_q) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_ACK;
                    ack_d   = 1'b1;
                    if (!we_q) begin
                        rdata_d = ill_q ? ERR_DATA : io_din;
                    end
                    if (ill_q) begin
                        bus_err_d = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                state_d = ST_ACK;
                ack_d   = 1'b1;
                rdata_d = dm_rdata;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            we_q      <= 1'b0;
            io_q      <= 1'b0;
            ill_q     <= 1'b0;
            dm_addr_q <= '0;
            io_addr_q <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            ack_q     <= 1'b0;
            dm_we_q   <= 1'b0;
            io_we_q   <= 1'b0;
            io_rd_q   <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            io_q      <= io_d;
            ill_q     <= ill_d;
            dm_addr_q <= dm_addr_d;
            io_addr_q <= io_addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            ack_q     <= ack_d;
            dm_we_q   <= dm_we_d;
            io_we_q   <= io_we_d;
            io_rd_q   <= io_rd_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign cpu_rdata = rdata_q;
    assign cpu_ack   = ack_q;
    assign dm_we     = dm_we_q;
    assign dm_addr   = dm_addr_q;
    assign dm_wdata  = wdata_q;
    assign io_addr   = io_addr_q;
    assign io_dout   = wdata_q;
    assign io_we     = io_we_q;
    assign io_rd     = io_rd_q;

`ifdef MMIO_ERR_EN
    assign bus_err = bus_err_q;
`else
    assign bus_err = 1'b0;
`endif

endmodule
